ab_seq_driver: RTL and testbench

//   Transmit side of the two-wire a/b control interface. Accepts queued commands (op, len),

---
 rtl/ab_drv_pkg.sv | 37 +++
 rtl/ab_cmd_fifo.sv | 59 +++++
 rtl/ab_seq_driver.sv | 166 ++++++++++++++++
 tb/tb_ab_seq_driver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ab_drv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : ab_drv_pkg                                            |
// | Purpose  : Shared types for the a/b sequence driver: command op  |
// |            codes, FSM state encoding and op -> {a,b} mapping.    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package ab_drv_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,  // a=0 b=0
    OP_STEP = 2'b01,  // a=1 b=0
    OP_PAIR = 2'b10,  // a=1 b=1
    OP_PARK = 2'b11   // a=0 b=1
  } ab_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } drv_state_e;

  // Returns the {a,b} pair driven for a given op code.
  function automatic logic [1:0] op_to_ab(input ab_op_e op);
    logic [1:0] ab;
    case (op)
      OP_HOLD: ab = 2'b00;
      OP_STEP: ab = 2'b10;
      OP_PAIR: ab = 2'b11;
      OP_PARK: ab = 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ab_cmd_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ab_cmd_fifo                                           |
// | Purpose  : Synchronous command FIFO. Pointers carry an extra     |
// |            wrap bit so full and empty are distinguishable.       |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module ab_cmd_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  // Pointer advance; callers guarantee no push when full and no pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; reset flushes the FIFO by equalising the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers are equal.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/ab_seq_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ab_seq_driver                                         |
// | Purpose  : Transmit side of the a/b control interface. Pops      |
// |            queued (op,len) commands, drives a/b for len cycles,  |
// |            idles one gap cycle, reports y0 count with done.      |
// | Options  : AB_CHECK_EN enables the sticky err protocol checker.  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module ab_seq_driver
  import ab_drv_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             a,
  output logic             b,
  input  logic             y0_in,
  input  logic             y1_in,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] pulse_cnt,
  output logic             err
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [LEN_W+1:0] fifo_rd_data;
  ab_op_e           head_op;
  logic [LEN_W-1:0] head_len;

  drv_state_e       state_q, state_d;
  ab_op_e           op_q, op_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             a_q, a_d, b_q, b_d, done_q, done_d;

  // y1 is status only; it never influences control.
  logic unused_y1;
  assign unused_y1 = y1_in;

  assign cmd_ready = !fifo_full;
  assign head_op   = ab_op_e'(fifo_rd_data[LEN_W+1:LEN_W]);
  assign head_len  = fifo_rd_data[LEN_W-1:0];

  ab_cmd_fifo #(
    .WIDTH (LEN_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_valid && !fifo_full),
    .wr_data ({cmd_op, cmd_len}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state, counters and registered output values for the command sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    pulse_cnt_d = pulse_cnt_q;
    a_d         = 1'b0;
    b_d         = 1'b0;
    done_d      = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_len != '0) begin
            state_d    = ST_DRIVE;
            op_d       = head_op;
            cnt_d      = head_len;
            acc_d      = '0;
            {a_d, b_d} = op_to_ab(head_op);
          end else begin
            // Zero-length command: skip straight to the gap with an empty count.
            state_d     = ST_GAP;
            done_d      = 1'b1;
            pulse_cnt_d = '0;
          end
        end
      end
      ST_DRIVE: begin
        if (y0_in && (acc_q != '1)) acc_d = acc_q + LEN_ONE;
        cnt_d = cnt_q - LEN_ONE;
        if (cnt_q == LEN_ONE) begin
          state_d     = ST_GAP;
          done_d      = 1'b1;
          pulse_cnt_d = acc_d;
        end else begin
          {a_d, b_d} = op_to_ab(op_q);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset discards any in-flight command without a done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_HOLD;
      cnt_q       <= '0;
      acc_q       <= '0;
      pulse_cnt_q <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      pulse_cnt_q <= pulse_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      done_q      <= done_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

`ifdef AB_CHECK_EN
  logic err_q, err_d;

  // A y0 pulse is only legal while both a and b are driven high.
  always_comb begin
    err_d = err_q | (y0_in & ~(a_q & b_q));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ab_seq_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_ab_seq_driver                                      |
// | Purpose  : Scoreboard bench for ab_seq_driver. Stimulus pushes   |
// |            expected {pattern, drive cycles, pulse count} per     |
// |            command; a monitor checks a/b and each done pulse.    |
// | Options  : AB_CHECK_EN adds the sticky err scenario.             |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_ab_seq_driver;

  typedef struct {
    logic [1:0] ab;
    int         drv;
    logic [3:0] pc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       a, b, busy, done, err;
  logic       y0_in = 1'b0;
  logic       y1_in = 1'b0;
  logic [3:0] pulse_cnt;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          drive_cnt = 0;
  int          y0_idx = 0;
  logic [15:0] y0_mask = 16'h0000;
  logic        force_y0 = 1'b0;

  ab_seq_driver #(.LEN_W(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .a         (a),
    .b         (b),
    .y0_in     (y0_in),
    .y1_in     (y1_in),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_ab(input logic [1:0] op);
    case (op)
      2'b00:   return 2'b00;
      2'b01:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: checks a/b against the command at the head of the scoreboard,
  // checks every done pulse, and plays the downstream FSM's y0 response.
  always @(negedge clk) begin
    if (!rst) begin
      drive_cnt = 0;
      y0_idx    = 0;
      y0_in     = force_y0;
    end else begin
      if ({a, b} != 2'b00) begin
        if (sb.size() == 0) check("ab_without_cmd", int'({a, b}), 0);
        else begin
          check("ab_pattern", int'({a, b}), int'(sb[0].ab));
          drive_cnt++;
        end
      end
      if (done) begin
        if (sb.size() == 0) check("done_unexpected", 1, 0);
        else begin
          check("pulse_cnt", int'(pulse_cnt), int'(sb[0].pc));
          check("drive_cycles", drive_cnt, sb[0].drv);
          void'(sb.pop_front());
        end
        drive_cnt = 0;
      end
      if (a && b) begin
        y0_in = force_y0 | y0_mask[y0_idx[3:0]];
        y0_idx++;
      end else begin
        y0_in  = force_y0;
        y0_idx = 0;
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [3:0] len, input logic [3:0] pc);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("push_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    sb.push_back('{ref_ab(op), (op == 2'b00) ? 0 : int'(len), pc});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || sb.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("idle_timeout", guard < 300 ? 1 : 0, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    cycles(3);
    #1;
    check("rst_ab", int'({a, b}), 0);
    check("rst_done", int'(done), 0);
    check("rst_pulse_cnt", int'(pulse_cnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_err", int'(err), 0);
    @(negedge clk) rst = 1'b1;
    cycles(2);

    // PAIR len=4, y0 on drive cycles 1 and 3
    y0_mask = 16'h0005;
    push(2'b10, 4'd4, 4'd2);
    wait_idle();
    y0_mask = 16'h0000;

    // STEP len=1 then HOLD len=3
    push(2'b01, 4'd1, 4'd0);
    push(2'b00, 4'd3, 4'd0);
    wait_idle();

    // PAIR len=15 with y0 every cycle: count reaches all-ones
    y0_mask = 16'hFFFF;
    push(2'b10, 4'd15, 4'd15);
    wait_idle();
    y0_mask = 16'h0000;

    // FIFO fill: long command occupies the FSM, four more fill the FIFO
    push(2'b11, 4'd8, 4'd0);
    cycles(2);
    push(2'b01, 4'd2, 4'd0);
    push(2'b11, 4'd3, 4'd0);
    push(2'b10, 4'd1, 4'd0);
    push(2'b01, 4'd4, 4'd0);
    check("fifo_full_ready", int'(cmd_ready), 0);
    check("fifo_full_busy", int'(busy), 1);
    push(2'b11, 4'd2, 4'd0);
    wait_idle();

    // len=0: no a/b activity, done on the second cycle after the push
    push(2'b10, 4'd0, 4'd0);
    @(negedge clk);
    check("len0_done_early", int'(done), 0);
    @(negedge clk);
    check("len0_done", int'(done), 1);
    wait_idle();

    // Reset mid-DRIVE of PAIR len=8: nothing may complete
    push(2'b10, 4'd8, 4'd0);
    push(2'b01, 4'd2, 4'd0);
    begin
      int guard = 0;
      while (!(a && b) && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      check("pair_start", int'(a && b), 1);
    end
    cycles(2);
    rst = 1'b0;
    #1;
    check("midrst_ab", int'({a, b}), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_done", int'(done), 0);
    sb.delete();
    cycles(2);
    rst = 1'b1;
    cycles(15);
    check("post_rst_busy", int'(busy), 0);

    // Normal operation resumes after the reset
    push(2'b11, 4'd2, 4'd0);
    wait_idle();

`ifdef AB_CHECK_EN
    check("err_clear", int'(err), 0);
    force_y0 = 1'b1;
    push(2'b00, 4'd3, 4'd3);
    @(negedge clk);
    check("err_set", int'(err), 1);
    wait_idle();
    force_y0 = 1'b0;
    cycles(5);
    check("err_sticky", int'(err), 1);
    rst = 1'b0;
    #1;
    check("err_rst", int'(err), 0);
    cycles(1);
    rst = 1'b1;
    cycles(2);
`else
    check("err_tied", int'(err), 0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
